// File: rtl/sound_irq_sched.sv
// sound_irq_sched: turns sound-latch writes into a delayed, retried active-low Z80 INT
// and counts writes dropped while a request is already outstanding.
module sound_irq_sched #(
  parameter int HOLDOFF   = 2,
  parameter int TIMEOUT   = 4096,
  parameter int MAX_RETRY = 3,
  parameter int CNTW      = 8
) (
  input  logic            clk_49m,
  input  logic            sirq_clr,
  input  logic            cen_3m,
  input  logic            n_cen_3m,
  input  logic            cs_soundlatch,
  output logic            z80_n_int,
  output logic            busy,
  output logic            fail,
  output logic [3:0]      retry_cnt,
  output logic            timeout_evt,
  output logic            overrun,
  output logic [CNTW-1:0] overrun_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_ASSERT, S_GAP, S_FAIL} state_t;
  localparam logic [3:0]  HOLD_LD = 4'(HOLDOFF);
  localparam logic [15:0] T_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  MAX_R   = 4'(MAX_RETRY);
  state_t            state_q, state_d;
  logic              req_flag_q, req_flag_d;
  logic [3:0]        hcnt_q, hcnt_d;
  logic [15:0]       tcnt_q, tcnt_d;
  logic [3:0]        retry_cnt_q, retry_cnt_d;
  logic              timeout_evt_q, timeout_evt_d;
  logic              overrun_q, overrun_d;
  logic [CNTW-1:0]   overrun_cnt_q, overrun_cnt_d;
  logic              z80_n_int_q, z80_n_int_d;
  logic [1:0]        rst_sync_q;
  logic              rst;
  // Clear asserts at once, releases two clocks later in step with clk_49m.
  always_ff @(posedge clk_49m or posedge sirq_clr)
    if (sirq_clr) rst_sync_q <= 2'b11;
    else          rst_sync_q <= {rst_sync_q[0], 1'b0};
  assign rst = rst_sync_q[1];
  always_comb begin
    state_d       = state_q;
    req_flag_d    = req_flag_q;
    hcnt_d        = hcnt_q;
    tcnt_d        = tcnt_q;
    retry_cnt_d   = retry_cnt_q;
    timeout_evt_d = 1'b0;
    overrun_d     = overrun_q;
    overrun_cnt_d = overrun_cnt_q;
    if (cen_3m && cs_soundlatch) begin
      if ((state_q == S_IDLE || state_q == S_FAIL) && !req_flag_q) req_flag_d = 1'b1;
      else begin
        overrun_d     = 1'b1;
        overrun_cnt_d = &overrun_cnt_q ? overrun_cnt_q : overrun_cnt_q + CNTW'(1);
      end
    end
    // Consumption only happens with req_flag_q set, so it never races the capture above.
    if (n_cen_3m)
      case (state_q)
        S_IDLE, S_FAIL:
          if (req_flag_q) begin
            req_flag_d  = 1'b0;
            retry_cnt_d = 4'd0;
            hcnt_d      = HOLD_LD;
            tcnt_d      = 16'd0;
            state_d     = HOLDOFF == 0 ? S_ASSERT : S_HOLD;
          end
        S_HOLD:
          if (hcnt_q == 4'd1) state_d = S_ASSERT;
          else                hcnt_d  = hcnt_q - 4'd1;
        S_ASSERT:
          if (tcnt_q == T_LAST) begin
            timeout_evt_d = 1'b1;
            tcnt_d        = 16'd0;
            if (retry_cnt_q < MAX_R) begin
              retry_cnt_d = retry_cnt_q + 4'd1;
              state_d     = S_GAP;
            end else state_d = S_FAIL;
          end else tcnt_d = tcnt_q + 16'd1;
        S_GAP: begin
          tcnt_d  = 16'd0;
          state_d = S_ASSERT;
        end
        default: state_d = S_IDLE;
      endcase
    z80_n_int_d = state_d != S_ASSERT;
  end
  always_ff @(posedge clk_49m or posedge rst)
    if (rst) begin
      state_q       <= S_IDLE;
      req_flag_q    <= 1'b0;
      hcnt_q        <= 4'd0;
      tcnt_q        <= 16'd0;
      retry_cnt_q   <= 4'd0;
      timeout_evt_q <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      z80_n_int_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      req_flag_q    <= req_flag_d;
      hcnt_q        <= hcnt_d;
      tcnt_q        <= tcnt_d;
      retry_cnt_q   <= retry_cnt_d;
      timeout_evt_q <= timeout_evt_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      z80_n_int_q   <= z80_n_int_d;
    end
  assign z80_n_int   = z80_n_int_q;
  assign busy        = state_q == S_HOLD || state_q == S_ASSERT || state_q == S_GAP;
  assign fail        = state_q == S_FAIL;
  assign retry_cnt   = retry_cnt_q;
  assign timeout_evt = timeout_evt_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
endmodule

// File: tb/tb_sound_irq_sched.sv
// tb_sound_irq_sched: scoreboard bench; expected INT edges (in n_cen_3m ticks) are queued
// when a write is driven and checked as the DUT's INT line moves.
module tb_sound_irq_sched;
  logic clk_49m = 1'b0, cen_3m, n_cen_3m, coin = 1'b0;
  logic clr_a = 1'b1, clr_b = 1'b1, cs_a = 1'b0, cs_b = 1'b0;
  logic [3:0] ph = 4'd0;
  logic za, busy_a, fail_a, to_a, ov_a, zb, busy_b, fail_b, to_b, ov_b;
  logic [3:0] rc_a, rc_b;
  logic [7:0] oc_a, oc_b;
  typedef struct {logic lvl; int tick;} ev_t;
  ev_t exp_q[$];
  int n_chk = 0, n_fail = 0, ntick = 0, to_cnt = 0;
  bit mon_en = 1'b0;
  logic prev_int = 1'b1;
  always #10 clk_49m = ~clk_49m;
  always @(posedge clk_49m) ph <= ph + 4'd1;
  assign cen_3m   = ph == 4'd0;
  assign n_cen_3m = ph == 4'd8 || (coin && ph == 4'd0);
  sound_irq_sched #(.HOLDOFF(2), .TIMEOUT(8), .MAX_RETRY(2), .CNTW(8)) u_a (
    .clk_49m(clk_49m), .sirq_clr(clr_a), .cen_3m(cen_3m), .n_cen_3m(n_cen_3m),
    .cs_soundlatch(cs_a), .z80_n_int(za), .busy(busy_a), .fail(fail_a), .retry_cnt(rc_a),
    .timeout_evt(to_a), .overrun(ov_a), .overrun_cnt(oc_a));
  sound_irq_sched #(.HOLDOFF(0), .TIMEOUT(8), .MAX_RETRY(2), .CNTW(8)) u_b (
    .clk_49m(clk_49m), .sirq_clr(clr_b), .cen_3m(cen_3m), .n_cen_3m(n_cen_3m),
    .cs_soundlatch(cs_b), .z80_n_int(zb), .busy(busy_b), .fail(fail_b), .retry_cnt(rc_b),
    .timeout_evt(to_b), .overrun(ov_b), .overrun_cnt(oc_b));
  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  always @(posedge clk_49m) begin
    logic n;
    ev_t e;
    n = n_cen_3m;
    #1;
    if (n) ntick++;
    if (to_a) to_cnt++;
    if (mon_en && za !== prev_int) begin
      if (exp_q.size() == 0) chk("int_unexpected_edge", za, prev_int);
      else begin
        e = exp_q.pop_front();
        chk("int_edge_level", za, e.lvl);
        chk("int_edge_tick", ntick, e.tick);
      end
    end
    prev_int = za;
  end
  task automatic wclk(input int n);
    repeat (n) @(negedge clk_49m);
  endtask
  task automatic write(input bit sel, input int cons_off, input bit push, output int fall);
    do @(negedge clk_49m); while (!cen_3m);
    fall = ntick + cons_off + 2;
    if (sel) cs_b = 1'b1; else cs_a = 1'b1;
    if (push) exp_q.push_back(ev_t'{lvl: 1'b0, tick: fall});
    @(negedge clk_49m);
    cs_a = 1'b0;
    cs_b = 1'b0;
  endtask
  task automatic wait_int(input logic lvl, input string tag);
    int i = 0;
    while (za !== lvl && i < 2000) begin
      @(negedge clk_49m);
      i++;
    end
    chk(tag, za, lvl);
  endtask
  task automatic clear_a();
    chk("sb_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    @(negedge clk_49m);
    #2 clr_a = 1'b1;
    #1;
    chk("clr_int", za, 1);
    chk("clr_busy", busy_a, 0);
    chk("clr_fail", fail_a, 0);
    chk("clr_retry", rc_a, 0);
    chk("clr_timeout_evt", to_a, 0);
    chk("clr_overrun", ov_a, 0);
    chk("clr_overrun_cnt", oc_a, 0);
    repeat (2) @(posedge clk_49m);
    #1 clr_a = 1'b0;
    wclk(4);
    exp_q.delete();
    mon_en = 1'b1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int f, n0, i;
    wclk(3);
    clr_a = 1'b0;
    clr_b = 1'b0;
    wclk(4);
    chk("rst_int", za, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_fail", fail_a, 0);
    chk("rst_retry", rc_a, 0);
    chk("rst_timeout_evt", to_a, 0);
    chk("rst_overrun", ov_a, 0);
    chk("rst_overrun_cnt", oc_a, 0);
    mon_en = 1'b1;
    write(1'b1, 1, 1'b0, f);
    // single command, HOLDOFF=2, then acknowledge while INT is low
    write(1'b0, 1, 1'b1, f);
    wait_int(1'b0, "t1_int_low");
    wclk(64);
    chk("t1_int_held", za, 0);
    chk("t1_busy", busy_a, 1);
    clear_a();
    // coincident enables: FSM must not consume on the capture edge
    coin = 1'b1;
    write(1'b0, 2, 1'b1, f);
    coin = 1'b0;
    chk("coin_still_idle", busy_a, 0);
    wait_int(1'b0, "coin_int_low");
    clear_a();
    // timeout/retry pattern low8/high1/low8/high1/low8 then FAIL
    to_cnt = 0;
    write(1'b0, 1, 1'b1, f);
    exp_q.push_back(ev_t'{lvl: 1'b1, tick: f + 8});
    exp_q.push_back(ev_t'{lvl: 1'b0, tick: f + 9});
    exp_q.push_back(ev_t'{lvl: 1'b1, tick: f + 17});
    exp_q.push_back(ev_t'{lvl: 1'b0, tick: f + 18});
    exp_q.push_back(ev_t'{lvl: 1'b1, tick: f + 26});
    i = 0;
    while (!fail_a && i < 1000) begin
      @(negedge clk_49m);
      i++;
    end
    chk("to_fail", fail_a, 1);
    chk("to_retry_cnt", rc_a, 2);
    chk("to_int_high", za, 1);
    chk("to_busy", busy_a, 0);
    chk("to_evt_count", to_cnt, 3);
    chk("to_sb_drained", exp_q.size(), 0);
    // recovery from FAIL
    write(1'b0, 1, 1'b1, f);
    wait_int(1'b0, "rec_int_low");
    chk("rec_retry_cnt", rc_a, 0);
    chk("rec_fail", fail_a, 0);
    clear_a();
    // overrun: one accepted write, three dropped
    write(1'b0, 1, 1'b1, f);
    for (int k = 0; k < 3; k++) write(1'b0, 1, 1'b0, n0);
    chk("ovr_flag", ov_a, 1);
    chk("ovr_cnt3", oc_a, 3);
    mon_en = 1'b0;
    cs_a = 1'b1;
    wclk(300 * 16);
    cs_a = 1'b0;
    chk("ovr_saturate", oc_a, 255);
    chk("ovr_flag_sticky", ov_a, 1);
    clear_a();
    // HOLDOFF=0 instance: recover from FAIL, INT low on the first n_cen edge after capture
    chk("b_fail", fail_b, 1);
    chk("b_retry_cnt", rc_b, 2);
    do @(negedge clk_49m); while (!cen_3m);
    n0 = ntick;
    cs_b = 1'b1;
    @(negedge clk_49m);
    cs_b = 1'b0;
    i = 0;
    while (zb !== 1'b0 && i < 200) begin
      @(negedge clk_49m);
      i++;
    end
    chk("b_int_low", zb, 0);
    chk("b_fall_tick", ntick, n0 + 1);
    chk("b_retry_cleared", rc_b, 0);
    chk("b_fail_cleared", fail_b, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
